imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction and its PC per handshake. For each instruction it produces:
- the XLEN-wide sign-extended immediate,
- a format code,
- an illegal-opcode flag,
- the PC-relative target (PC + imm).

It sits between fetch and register-read. A valid/ready skid buffer lets it absorb back-pressure from the execute stage without combinational ready paths. It also supports flush.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64. At 64, the RV64 OP-IMM-32/OP-32 opcodes are decoded.
- SKID, 1, selects the buffering mode:
  - 1: 2-entry skid buffer; in_ready is driven from a flop.
  - 0: single output register; in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of the instruction
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  instruction, passed through unchanged
- out_pc  out  XLEN  PC, passed through unchanged
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 none
- out_illegal  out  1  opcode not recognised
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN

## Operation
Decode is combinational on in_inst. Results are captured together with in_inst and in_pc on every accepted beat (in_valid && in_ready).

Decode by opcode in_inst[6:0]:
- 0110011 → R, imm 0. At XLEN=64, 0111011 also decodes as R.
- 0010011, 0000011, 1100111, 0001111 → I, imm = sext(inst[31:20]). At XLEN=64, 0011011 also decodes as I.
- 1110011:
  - funct3[2]=1 → Z, imm = zext(inst[19:15]).
  - otherwise → I, imm = sext(inst[31:20]).
- 0100011 → S, imm = sext({inst[31:25], inst[11:7]}).
- 1100011 → B, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- 0110111, 0010111 → U, imm = sext({inst[31:12], 12'b0}). At XLEN=64 this means bits 63:32 copy inst[31].
- 1101111 → J, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Any other opcode, or inst[1:0] != 2'b11 → fmt 7, imm 0, out_illegal=1.

out_target is computed for every beat, whatever the format. Downstream decides whether to use it.

SKID=1 behaviour:
- Output register holds the head beat; the skid register holds one extra beat.
- in_ready = !skid_valid.
- A beat accepted while the output is valid and not draining goes to the skid register.
- When the output drains, skid contents move to the output register before any new beat.
- Beats leave in order; none are dropped or duplicated.

Reset and flush:
- rst and flush have identical effect next edge: out_valid=0, skid empty, in_ready=1.
- A beat presented in the same cycle as flush is discarded.
- rst has priority over everything.
- Data outputs reset to 0, out_fmt to 7, out_illegal to 0.
- Payload registers are loaded only on capture. They hold their values while out_valid=0 or while stalled.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented at out_* after edge N.
- Full throughput (1 beat/cycle) while out_ready=1.
- out_* must stay stable while out_valid && !out_ready.
- SKID=1: in_ready deasserts the cycle after the second beat is held under stall, and reasserts the cycle after the output drains.
- SKID=0: in_ready is combinational from out_ready.
- Flush is effective in 1 cycle: out_valid is low after the flush edge, regardless of out_ready.
- In the same cycle, a drain and a new beat are simultaneous: the output reloads from skid if skid is occupied, otherwise from input. Occupancy never exceeds 2.

## Test plan
- XLEN=32, pc=0x100, inst 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, fmt 1, target 0x0FF, illegal 0.
- inst 0x00112623 (sw x1,12(x2)) → imm 0x0000000C, fmt 2. Then inst 0xFE000EE3 (beq -4) at pc=0x200 → imm 0xFFFFFFFC, fmt 3, target 0x1FC.
- inst 0x001000EF (jal x1,+2048) at pc=0x1000 → imm 0x800, fmt 5, target 0x1800. Then inst 0x0FF5D073 (csrrwi x0,0xFF,11) → imm 0xB, fmt 6.
- XLEN=64: inst 0x800002B7 (lui x5,0x80000) → imm 0xFFFFFFFF80000000, fmt 4. Then inst 0x00000000 → fmt 7, illegal 1, imm 0.
- SKID=1: stream 6 back-to-back beats while out_ready=0 for 3 cycles → in_ready low after 2 held beats, all 6 emerge in order, none lost or duplicated, out_* stable during the stall.
- With 2 beats buffered, assert flush together with a new in_valid beat → next cycle out_valid=0 and in_ready=1, and the flushed beat never appears. A mid-stream rst gives the same result.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate/target decoder with valid/ready skid buffering and flush.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);
  localparam bit WIDE = (XLEN == 64);
  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] target;
  } beat_t;
  beat_t dec, out_r, rst_beat;
  logic out_v, accept, free;
  logic [6:0] op;
  logic [2:0] fmt;
  logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  assign op    = in_inst[6:0];
  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm_z = XLEN'(in_inst[19:15]);
  // Every listed opcode ends in 2'b11, so compressed encodings fall to the illegal default.
  always_comb begin
    fmt = 3'd7;
    imm = '0;
    case (op)
      7'b0110011: fmt = 3'd0;
      7'b0111011: fmt = WIDE ? 3'd0 : 3'd7;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
        fmt = 3'd1;
        imm = imm_i;
      end
      7'b0011011: begin
        fmt = WIDE ? 3'd1 : 3'd7;
        imm = WIDE ? imm_i : '0;
      end
      7'b1110011: begin
        fmt = in_inst[14] ? 3'd6 : 3'd1;
        imm = in_inst[14] ? imm_z : imm_i;
      end
      7'b0100011: begin
        fmt = 3'd2;
        imm = imm_s;
      end
      7'b1100011: begin
        fmt = 3'd3;
        imm = imm_b;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4;
        imm = imm_u;
      end
      7'b1101111: begin
        fmt = 3'd5;
        imm = imm_j;
      end
      default: ;
    endcase
  end
  assign dec      = {in_inst, in_pc, imm, fmt, fmt == 3'd7, in_pc + imm};
  assign rst_beat = {{(32 + 2 * XLEN){1'b0}}, 3'd7, 1'b0, {XLEN{1'b0}}};
  assign accept   = in_valid && in_ready;
  assign free     = !out_v || out_ready;
  generate
    if (SKID) begin : g_skid
      beat_t skid_r;
      logic  skid_v;
      // Skid is drained into the output ahead of any new beat; in_ready is low while it is full.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_v  <= 1'b0;
          skid_v <= 1'b0;
          out_r  <= rst_beat;
          skid_r <= rst_beat;
        end else if (flush) begin
          out_v  <= 1'b0;
          skid_v <= 1'b0;
        end else if (free) begin
          out_v  <= skid_v || accept;
          skid_v <= 1'b0;
          if (skid_v) out_r <= skid_r;
          else if (accept) out_r <= dec;
        end else if (accept) begin
          skid_v <= 1'b1;
          skid_r <= dec;
        end
      end
      assign in_ready = !skid_v;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          out_v <= 1'b0;
          out_r <= rst_beat;
        end else if (flush) begin
          out_v <= 1'b0;
        end else if (free) begin
          out_v <= accept;
          if (accept) out_r <= dec;
        end
      end
      assign in_ready = free;
    end
  endgenerate
  assign out_valid = out_v;
  assign {out_inst, out_pc, out_imm, out_fmt, out_illegal, out_target} = out_r;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench over three configurations (32/skid, 64/skid, 32/no-skid).
module tb_imm_gen_pipe;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, imm, target;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  int checks = 0, errors = 0, drains0 = 0;
  bit started = 1'b0;
  exp_t q[3][$];

  logic r0, v0, ill0, r1, v1, ill1, r2, v2, ill2;
  logic [31:0] i0, i1, i2, pc0, imm0, tg0, pc2, imm2, tg2;
  logic [63:0] pc1, imm1, tg1;
  logic [2:0] fmt0, fmt1, fmt2;

  imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) d32 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r0), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(v0), .out_ready(out_ready), .out_inst(i0), .out_pc(pc0), .out_imm(imm0),
    .out_fmt(fmt0), .out_illegal(ill0), .out_target(tg0));
  imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) d64 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r1), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(v1), .out_ready(out_ready), .out_inst(i1), .out_pc(pc1), .out_imm(imm1),
    .out_fmt(fmt1), .out_illegal(ill1), .out_target(tg1));
  imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) d0 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r2), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(v2), .out_ready(out_ready), .out_inst(i2), .out_pc(pc2), .out_imm(imm2),
    .out_fmt(fmt2), .out_illegal(ill2), .out_target(tg2));

  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, a, e);
    end
  endtask

  // Reference decode from the opcode table, done in 64-bit arithmetic and folded to XLEN.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc, input bit w64);
    exp_t e;
    logic [6:0] op;
    logic [63:0] m;
    op = i[6:0];
    m = w64 ? '1 : 64'hFFFF_FFFF;
    e.inst = i;
    e.pc = pc & m;
    e.fmt = 3'd7;
    e.imm = 0;
    if (op == 7'h33 || (w64 && op == 7'h3B)) e.fmt = 3'd0;
    else if (op inside {7'h13, 7'h03, 7'h67, 7'h0F} || (w64 && op == 7'h1B) || (op == 7'h73 && !i[14])) begin
      e.fmt = 3'd1; e.imm = 64'($signed(i[31:20]));
    end else if (op == 7'h73) begin
      e.fmt = 3'd6; e.imm = {59'b0, i[19:15]};
    end else if (op == 7'h23) begin
      e.fmt = 3'd2; e.imm = 64'($signed({i[31:25], i[11:7]}));
    end else if (op == 7'h63) begin
      e.fmt = 3'd3; e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    end else if (op == 7'h37 || op == 7'h17) begin
      e.fmt = 3'd4; e.imm = 64'($signed(i[31:12])) * 64'd4096;
    end else if (op == 7'h6F) begin
      e.fmt = 3'd5; e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    end
    e.ill = (e.fmt == 3'd7);
    e.imm &= m;
    e.target = (e.pc + e.imm) & m;
    return e;
  endfunction

  task automatic chk(input int k, input logic ov, input logic ir, input logic [31:0] oi,
                     input logic [63:0] opc, input logic [63:0] oimm, input logic [2:0] ofmt,
                     input logic oill, input logic [63:0] otgt, input bit w64, input bit sk);
    int n;
    n = q[k].size();
    cmp($sformatf("u%0d out_valid", k), ov, n != 0);
    cmp($sformatf("u%0d in_ready", k), ir, sk ? (n < 2) : (n == 0 || out_ready));
    if (ov && n != 0) begin
      cmp($sformatf("u%0d inst", k), oi, q[k][0].inst);
      cmp($sformatf("u%0d pc", k), opc, q[k][0].pc);
      cmp($sformatf("u%0d imm", k), oimm, q[k][0].imm);
      cmp($sformatf("u%0d fmt", k), ofmt, q[k][0].fmt);
      cmp($sformatf("u%0d illegal", k), oill, q[k][0].ill);
      cmp($sformatf("u%0d target", k), otgt, q[k][0].target);
      if (out_ready) begin
        void'(q[k].pop_front());
        if (k == 0) drains0++;
      end
    end
    if (in_valid && ir && !flush && !rst) q[k].push_back(model(in_inst, in_pc, w64));
    if (flush || rst) q[k].delete();
  endtask

  always @(negedge clk) if (started) begin
    chk(0, v0, r0, i0, pc0, imm0, fmt0, ill0, tg0, 1'b0, 1'b1);
    chk(1, v1, r1, i1, pc1, imm1, fmt1, ill1, tg1, 1'b1, 1'b1);
    chk(2, v2, r2, i2, pc2, imm2, fmt2, ill2, tg2, 1'b0, 1'b0);
  end

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [12] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h001000EF,
                            32'h0FF5D073, 32'h800002B7, 32'h00000000, 32'h002081BB,
                            32'hFFF0009B, 32'h00000010, 32'h80001017, 32'h34202373};
  exp_t m;
  int idx;
  bit acc;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = '0; in_pc = '0;
    @(posedge clk); #1 started = 1'b1;
    @(posedge clk); #1;
    cmp("rst out_valid", v0, 0); cmp("rst in_ready", r0, 1); cmp("rst fmt", fmt0, 7);
    cmp("rst imm", imm0, 0); cmp("rst illegal", ill0, 0); cmp("rst target64", tg1, 0);
    cmp("rst in_ready noskid", r2, 1);
    rst = 1'b0;
    m = model(32'hFFF00093, 64'h100, 1'b0);
    cmp("model addi imm", m.imm, 64'hFFFF_FFFF); cmp("model addi target", m.target, 64'hFF);
    m = model(32'hFE000EE3, 64'h200, 1'b0);
    cmp("model beq target", m.target, 64'h1FC);
    m = model(32'h800002B7, 64'h0, 1'b1);
    cmp("model lui imm", m.imm, 64'hFFFF_FFFF_8000_0000);
    m = model(32'h0FF5D073, 64'h0, 1'b0);
    cmp("model csrrwi imm", m.imm, 64'hB); cmp("model csrrwi fmt", m.fmt, 6);
    send(32'hFFF00093, 64'h100);
    cmp("addi imm", imm0, 32'hFFFF_FFFF); cmp("addi fmt", fmt0, 1);
    cmp("addi target", tg0, 32'hFF); cmp("addi illegal", ill0, 0);
    send(32'h00112623, 64'h104);
    cmp("sw imm", imm0, 32'hC); cmp("sw fmt", fmt0, 2);
    send(32'hFE000EE3, 64'h200);
    cmp("beq imm", imm0, 32'hFFFF_FFFC); cmp("beq fmt", fmt0, 3); cmp("beq target", tg0, 32'h1FC);
    send(32'h001000EF, 64'h1000);
    cmp("jal imm", imm0, 32'h800); cmp("jal fmt", fmt0, 5); cmp("jal target", tg0, 32'h1800);
    send(32'h0FF5D073, 64'h1004);
    cmp("csrrwi imm", imm0, 32'hB); cmp("csrrwi fmt", fmt0, 6);
    send(32'h800002B7, 64'h0);
    cmp("lui64 imm", imm1, 64'hFFFF_FFFF_8000_0000); cmp("lui64 fmt", fmt1, 4);
    send(32'h00000000, 64'h8);
    cmp("zero fmt", fmt1, 7); cmp("zero illegal", ill1, 1); cmp("zero imm", imm1, 0);
    idle(2);
    for (int c = 0; c < 80; c++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_inst = tbl[$urandom_range(11)];
      in_pc = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    idle(4);
    drains0 = 0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      in_valid = 1'b1; in_inst = tbl[idx]; in_pc = 64'h4000 + 64'(idx * 4);
      out_ready = (c >= 3);
      acc = r0;
      if (c == 2) cmp("stall in_ready low", r0, 0);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    cmp("stall all accepted", idx, 6);
    idle(4);
    cmp("stall drained count", drains0, 6);
    for (int v = 0; v < 2; v++) begin
      out_ready = 1'b0;
      send(32'h00A00513, 64'h500);
      send(32'h00B00593, 64'h504);
      cmp("kill pre in_ready", r0, 0);
      in_valid = 1'b1; in_inst = 32'h00C00613; in_pc = 64'h508;
      if (v == 0) flush = 1'b1; else rst = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; rst = 1'b0; in_valid = 1'b0;
      cmp("kill out_valid", v0, 0); cmp("kill in_ready", r0, 1);
      cmp("kill out_valid64", v1, 0); cmp("kill out_valid noskid", v2, 0);
      cmp("kill in_ready noskid", r2, 1);
      idle(3);
    end
    in_valid = 1'b1; in_inst = 32'h00D00693; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    cmp("flush empty out_valid", v0, 0);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
